sad_column_scheduler: RTL and testbench
=======================================

# sad_column_scheduler

- Sits between the stereo line buffers and the `sad` disparity engine.
- Accepts 3-row pixel columns from both cameras and buffers them in a small FIFO, because `sad` is busy for OFFSET+1 cycles per column.
- Issues one column to `sad` at a time, waits out its busy window, and turns each `line_out` result into an addressed write to the depth frame buffer.
- Also masks invalid edge disparities, counts dropped columns and engine timeouts, and flags the end of each frame.

## Interface
Parameters:
- KERNEL_SIZE, 3, rows per column / kernel width
- OFFSET, 10, disparity search range of the engine
- FIFO_DEPTH, 4, buffered columns (power of two)
- H_ACTIVE, 320, pixels per line
- V_ACTIVE, 240, lines per frame

Ports:
- clk_in  in  1  system clock
- rst_n_in  in  1  reset; one clock; reset is asynchronous and active-low
- col_valid_in  in  1  upstream column strobe; no stall, so a column is lost if it is not accepted
- col_ready_out  out  1  FIFO not full (advisory)
- left_col_in  in  [KERNEL_SIZE][8]  left column, index 0 = top row
- right_col_in  in  [KERNEL_SIZE][8]  right column
- hcount_in  in  11  column x
- vcount_in  in  10  column y
- sad_valid_out  out  1  one-cycle issue strobe to engine `data_valid_in`
- sad_left_out  out  [KERNEL_SIZE][8]  issued left column
- sad_right_out  out  [KERNEL_SIZE][8]  issued right column
- sad_hcount_out  out  11  issued x
- sad_vcount_out  out  10  issued y
- sad_busy_in  in  1  engine busy
- sad_valid_in  in  1  engine result strobe
- sad_line_in  in  8  engine result (best offset)
- sad_hcount_in  in  10  result x
- sad_vcount_in  in  9  result y
- depth_valid_out  out  1  depth write strobe
- depth_addr_out  out  17  depth address, = y*H_ACTIVE + x
- depth_data_out  out  8  depth value
- frame_done_out  out  1  one-cycle pulse at the last pixel write of a frame
- drop_count_out  out  16  columns lost to a full FIFO; saturates at 0xFFFF
- timeout_count_out  out  16  watchdog aborts; saturates at 0xFFFF

## Operation
- **Push rule:** a column is accepted when col_valid_in=1 and (FIFO not full, or a pop occurs in the same cycle). Otherwise drop_count_out increments.
- **FSM state IDLE:** if the FIFO is non-empty, pop the head, register it onto the sad_* outputs, pulse sad_valid_out and go to WAIT_BUSY.
- **FSM state WAIT_BUSY:** when sad_busy_in=1, go to WAIT_RESULT.
- **FSM state WAIT_RESULT:** when sad_valid_in=1, capture the result and go to IDLE.
- **Watchdog:** the counter clears on issue and runs through WAIT_BUSY and WAIT_RESULT. On reaching 2*OFFSET+4 (24) cycles, return to IDLE and increment timeout_count_out.
- **Stray results:** sad_valid_in outside WAIT_RESULT is ignored and produces no write.
- **Write value:**
  - depth_data_out = 0 when sad_hcount_in < OFFSET+KERNEL_SIZE-1 (edge mask);
  - otherwise depth_data_out = sad_line_in.
- **All columns are issued,** including edge columns, since the engine's caches depend on every column arriving.
- **Address arithmetic:** computed as 17-bit unsigned. Results with x ≥ H_ACTIVE or y ≥ V_ACTIVE produce no write.
- **frame_done_out:** asserted together with the depth write whose x=H_ACTIVE-1 and y=V_ACTIVE-1.

## Timing
- **Reset values:**
  - all outputs 0, except col_ready_out=1;
  - FIFO empty, FSM in IDLE, both counters 0.
- **Reset mid-operation:** takes effect immediately. An in-flight result arriving after reset is ignored.
- **FIFO:** registered, so a push in cycle N makes the entry poppable in N+1.
- **Issue latency:** a column pushed at N into an empty FIFO with the FSM in IDLE produces sad_valid_out=1 in cycle N+2, held for exactly one cycle.
- **Write latency:** sad_valid_in in cycle R produces depth_valid_out in cycle R+1, held for one cycle.
- **Throughput:** at most one column per OFFSET+3 cycles with the nominal engine.

## Structure
- **Package `sad_pkg`:**
  - constants KERNEL_SIZE, OFFSET, H_ACTIVE, V_ACTIVE;
  - `sched_state_t` enum {IDLE, WAIT_BUSY, WAIT_RESULT};
  - `sad_column_t` struct {left, right, hcount, vcount}.
- **Sub-module `column_fifo`:**
  - synchronous FIFO of `sad_column_t`, FIFO_DEPTH entries;
  - push/pop/full/empty ports, with simultaneous push+pop allowed when full.

## Test plan
- **Single issue:** push column x=50, y=10 at cycle 0 → sad_valid_out high only in cycle 2. Engine returns line=7 at cycle R → depth_valid_out at R+1 with addr 3250, data 7.
- **Overflow:** push 8 back-to-back columns while the engine model stays busy 11 cycles → column 0 issued, 4 buffered, drop_count_out=3, col_ready_out low from cycle 5.
- **Edge mask:** result with x=5, line=9 → depth_data_out=0. The same result with x=12 → depth_data_out=9.
- **Watchdog:** engine never raises sad_valid_in → timeout_count_out=1 exactly 24 cycles after issue, then the next queued column issues.
- **Frame end:** result with x=319, y=239 → depth write to addr 76799 with frame_done_out=1 in the same cycle.
- **Async reset:** drop rst_n_in mid-WAIT_RESULT → all outputs 0 without waiting for a clock edge. A subsequent sad_valid_in produces no depth write.

Source files
------------

// File: rtl/sad_pkg.sv
// Shared constants, state encoding and column payload for the SAD column scheduler.
package sad_pkg;
  localparam int unsigned KERNEL_SIZE = 3;
  localparam int unsigned OFFSET      = 10;
  localparam int unsigned H_ACTIVE    = 320;
  localparam int unsigned V_ACTIVE    = 240;
  localparam int unsigned PIX_W       = 8;
  localparam int unsigned HCOUNT_W    = 11;
  localparam int unsigned VCOUNT_W    = 10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_RESULT
  } sched_state_t;

  typedef struct packed {
    logic [KERNEL_SIZE-1:0][PIX_W-1:0] left;
    logic [KERNEL_SIZE-1:0][PIX_W-1:0] right;
    logic [HCOUNT_W-1:0]               hcount;
    logic [VCOUNT_W-1:0]               vcount;
  } sad_column_t;

  // Saturating 16-bit event counter step.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/column_fifo.sv
// Small synchronous FIFO of stereo columns; push is accepted when full if a pop happens in the same cycle.
module column_fifo
  import sad_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  sad_column_t wdata,
  output sad_column_t head_c,
  output logic        full,
  output logic        empty
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  sad_column_t   mem_q [DEPTH];
  sad_column_t   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop && !empty_q;
    do_push  = push && (!full_q || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign head_c = mem_q[rd_ptr_q];
  assign full   = full_q;
  assign empty  = empty_q;
endmodule

// File: rtl/sad_column_scheduler.sv
// Buffers stereo columns, issues them one at a time to the SAD engine, and
// converts engine results into addressed depth-buffer writes with a watchdog.
module sad_column_scheduler #(
  parameter int unsigned KERNEL_SIZE = sad_pkg::KERNEL_SIZE,
  parameter int unsigned OFFSET      = sad_pkg::OFFSET,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned H_ACTIVE    = sad_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE    = sad_pkg::V_ACTIVE
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic                        col_valid_in,
  output logic                        col_ready_out,
  input  logic [KERNEL_SIZE-1:0][7:0] left_col_in,
  input  logic [KERNEL_SIZE-1:0][7:0] right_col_in,
  input  logic [10:0]                 hcount_in,
  input  logic [9:0]                  vcount_in,
  output logic                        sad_valid_out,
  output logic [KERNEL_SIZE-1:0][7:0] sad_left_out,
  output logic [KERNEL_SIZE-1:0][7:0] sad_right_out,
  output logic [10:0]                 sad_hcount_out,
  output logic [9:0]                  sad_vcount_out,
  input  logic                        sad_busy_in,
  input  logic                        sad_valid_in,
  input  logic [7:0]                  sad_line_in,
  input  logic [9:0]                  sad_hcount_in,
  input  logic [8:0]                  sad_vcount_in,
  output logic                        depth_valid_out,
  output logic [16:0]                 depth_addr_out,
  output logic [7:0]                  depth_data_out,
  output logic                        frame_done_out,
  output logic [15:0]                 drop_count_out,
  output logic [15:0]                 timeout_count_out
);
  import sad_pkg::*;

  localparam int unsigned WD_LIMIT = 2 * OFFSET + 4;
  localparam int unsigned WD_W     = $clog2(WD_LIMIT + 1);
  localparam int unsigned EDGE_X   = OFFSET + KERNEL_SIZE - 1;
  localparam int unsigned ADDR_W   = 17;

  sched_state_t      state_q, state_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  sad_column_t       sad_col_q, sad_col_d;
  logic              sad_valid_q, sad_valid_d;
  logic              depth_valid_q, depth_valid_d;
  logic [ADDR_W-1:0] depth_addr_q, depth_addr_d;
  logic [7:0]        depth_data_q, depth_data_d;
  logic              frame_done_q, frame_done_d;
  logic [15:0]       drop_q, drop_d;
  logic [15:0]       timeout_q, timeout_d;

  sad_column_t col_in, fifo_head;
  logic        col_push, fifo_pop, fifo_full, fifo_empty;
  logic        res_in_range, res_last_pixel;

  assign col_in = '{left: left_col_in, right: right_col_in, hcount: hcount_in, vcount: vcount_in};

  column_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk_in),
    .rst_n  (rst_n_in),
    .push   (col_push),
    .pop    (fifo_pop),
    .wdata  (col_in),
    .head_c (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign res_in_range   = (sad_hcount_in < 10'(H_ACTIVE)) && (sad_vcount_in < 9'(V_ACTIVE));
  assign res_last_pixel = (sad_hcount_in == 10'(H_ACTIVE - 1)) && (sad_vcount_in == 9'(V_ACTIVE - 1));

  // Issue / result FSM with watchdog and push-side drop accounting.
  always_comb begin
    state_d       = state_q;
    wd_d          = wd_q;
    sad_col_d     = sad_col_q;
    sad_valid_d   = 1'b0;
    depth_valid_d = 1'b0;
    depth_addr_d  = depth_addr_q;
    depth_data_d  = depth_data_q;
    frame_done_d  = 1'b0;
    drop_d        = drop_q;
    timeout_d     = timeout_q;
    fifo_pop      = 1'b0;
    col_push      = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          sad_col_d   = fifo_head;
          sad_valid_d = 1'b1;
          wd_d        = '0;
          state_d     = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        wd_d = wd_q + WD_W'(1);
        if (sad_busy_in) begin
          state_d = WAIT_RESULT;
        end
      end
      WAIT_RESULT: begin
        wd_d = wd_q + WD_W'(1);
        if (sad_valid_in) begin
          state_d = IDLE;
          if (res_in_range) begin
            depth_valid_d = 1'b1;
            depth_addr_d  = ADDR_W'(sad_vcount_in) * ADDR_W'(H_ACTIVE) + ADDR_W'(sad_hcount_in);
            depth_data_d  = (sad_hcount_in < 10'(EDGE_X)) ? 8'd0 : sad_line_in;
            frame_done_d  = res_last_pixel;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A result captured in the final watchdog cycle wins over the abort.
    if ((state_q != IDLE) && (state_d != IDLE) && (wd_q == WD_W'(WD_LIMIT - 1))) begin
      state_d   = IDLE;
      timeout_d = sat_inc16(timeout_q);
    end

    col_push = col_valid_in && (!fifo_full || fifo_pop);
    if (col_valid_in && !col_push) begin
      drop_d = sat_inc16(drop_q);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= IDLE;
      wd_q          <= '0;
      sad_col_q     <= '0;
      sad_valid_q   <= 1'b0;
      depth_valid_q <= 1'b0;
      depth_addr_q  <= '0;
      depth_data_q  <= '0;
      frame_done_q  <= 1'b0;
      drop_q        <= '0;
      timeout_q     <= '0;
    end else begin
      state_q       <= state_d;
      wd_q          <= wd_d;
      sad_col_q     <= sad_col_d;
      sad_valid_q   <= sad_valid_d;
      depth_valid_q <= depth_valid_d;
      depth_addr_q  <= depth_addr_d;
      depth_data_q  <= depth_data_d;
      frame_done_q  <= frame_done_d;
      drop_q        <= drop_d;
      timeout_q     <= timeout_d;
    end
  end

  assign col_ready_out     = ~fifo_full;
  assign sad_valid_out     = sad_valid_q;
  assign sad_left_out      = sad_col_q.left;
  assign sad_right_out     = sad_col_q.right;
  assign sad_hcount_out    = sad_col_q.hcount;
  assign sad_vcount_out    = sad_col_q.vcount;
  assign depth_valid_out   = depth_valid_q;
  assign depth_addr_out    = depth_addr_q;
  assign depth_data_out    = depth_data_q;
  assign frame_done_out    = frame_done_q;
  assign drop_count_out    = drop_q;
  assign timeout_count_out = timeout_q;
endmodule

// File: tb/tb_sad_column_scheduler.sv
// Directed scoreboard bench for sad_column_scheduler with a small SAD engine model.
module tb_sad_column_scheduler;
  logic             clk_in = 1'b0;
  logic             rst_n_in;
  logic             col_valid_in;
  logic             col_ready_out;
  logic [2:0][7:0]  left_col_in, right_col_in;
  logic [10:0]      hcount_in;
  logic [9:0]       vcount_in;
  logic             sad_valid_out;
  logic [2:0][7:0]  sad_left_out, sad_right_out;
  logic [10:0]      sad_hcount_out;
  logic [9:0]       sad_vcount_out;
  logic             sad_busy_in, sad_valid_in;
  logic [7:0]       sad_line_in;
  logic [9:0]       sad_hcount_in;
  logic [8:0]       sad_vcount_in;
  logic             depth_valid_out;
  logic [16:0]      depth_addr_out;
  logic [7:0]       depth_data_out;
  logic             frame_done_out;
  logic [15:0]      drop_count_out, timeout_count_out;

  // Engine model (eng_*) and manually driven engine pins (man_*).
  int          eng_mode = 0;
  int          eng_left = 0;
  logic        eng_busy = 1'b0, eng_valid = 1'b0;
  logic [9:0]  eng_x = '0;
  logic [8:0]  eng_y = '0;
  logic [7:0]  line_val = '0;
  logic        man_busy, man_valid;
  logic [9:0]  man_x;
  logic [8:0]  man_y;
  logic [7:0]  man_line;

  typedef struct {
    logic [10:0] x;
    logic [9:0]  y;
    logic [23:0] l;
    logic [23:0] r;
    int          cyc;
  } iss_t;
  typedef struct {
    logic [16:0] addr;
    logic [7:0]  data;
    logic        fd;
    int          cyc;
  } wr_t;

  iss_t iq[$];
  wr_t  wq[$];
  int   cyc = 0;
  int   n_checks = 0, n_pass = 0, n_fail = 0;
  int   n_writes = 0, n_fd = 0;

  assign sad_busy_in   = eng_busy | man_busy;
  assign sad_valid_in  = eng_valid | man_valid;
  assign sad_hcount_in = (eng_mode != 0) ? eng_x : man_x;
  assign sad_vcount_in = (eng_mode != 0) ? eng_y : man_y;
  assign sad_line_in   = (eng_mode != 0) ? line_val : man_line;

  sad_column_scheduler dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .col_valid_in(col_valid_in), .col_ready_out(col_ready_out),
    .left_col_in(left_col_in), .right_col_in(right_col_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .sad_valid_out(sad_valid_out), .sad_left_out(sad_left_out), .sad_right_out(sad_right_out),
    .sad_hcount_out(sad_hcount_out), .sad_vcount_out(sad_vcount_out),
    .sad_busy_in(sad_busy_in), .sad_valid_in(sad_valid_in), .sad_line_in(sad_line_in),
    .sad_hcount_in(sad_hcount_in), .sad_vcount_in(sad_vcount_in),
    .depth_valid_out(depth_valid_out), .depth_addr_out(depth_addr_out),
    .depth_data_out(depth_data_out), .frame_done_out(frame_done_out),
    .drop_count_out(drop_count_out), .timeout_count_out(timeout_count_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Engine: busy for 11 cycles after an issue, result on the last busy cycle (mode 1) or never (mode 2).
  always @(posedge clk_in) begin
    wr_t w;
    #1;
    eng_valid = 1'b0;
    if (eng_left != 0) begin
      eng_busy = 1'b1;
      eng_left--;
      if (eng_left == 0 && eng_mode == 1) begin
        eng_valid = 1'b1;
        if (eng_x < 10'd320 && eng_y < 9'd240) begin
          w.addr = 17'(32'(eng_y) * 320 + 32'(eng_x));
          w.data = (eng_x < 10'd12) ? 8'd0 : line_val;
          w.fd   = (eng_x == 10'd319) && (eng_y == 9'd239);
          w.cyc  = cyc + 1;
          wq.push_back(w);
        end
      end
    end else begin
      eng_busy = 1'b0;
    end
    if (sad_valid_out && eng_mode != 0 && rst_n_in) begin
      eng_left = 11;
      eng_x    = sad_hcount_out[9:0];
      eng_y    = sad_vcount_out[8:0];
    end
  end

  // Output monitor: pops scoreboard entries as the DUT issues columns and writes depth.
  always @(negedge clk_in) begin
    iss_t e;
    wr_t  w;
    if (rst_n_in) begin
      if (sad_valid_out) begin
        check("issue_expected", 32'(iq.size() != 0), 32'd1);
        if (iq.size() != 0) begin
          e = iq.pop_front();
          check("issue_x", 32'(sad_hcount_out), 32'(e.x));
          check("issue_y", 32'(sad_vcount_out), 32'(e.y));
          check("issue_left", 32'(sad_left_out), 32'(e.l));
          check("issue_right", 32'(sad_right_out), 32'(e.r));
          if (e.cyc >= 0) check("issue_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (depth_valid_out) begin
        n_writes++;
        if (frame_done_out) n_fd++;
        check("write_expected", 32'(wq.size() != 0), 32'd1);
        if (wq.size() != 0) begin
          w = wq.pop_front();
          check("write_addr", 32'(depth_addr_out), 32'(w.addr));
          check("write_data", 32'(depth_data_out), 32'(w.data));
          check("write_frame_done", 32'(frame_done_out), 32'(w.fd));
          check("write_cycle", 32'(cyc), 32'(w.cyc));
        end
      end else if (frame_done_out) begin
        check("frame_done_without_write", 32'(frame_done_out), 32'd0);
      end
    end
  end

  task automatic drive_col(input logic [10:0] x, input logic [9:0] y, input int exp_cyc, input bit accept);
    iss_t e;
    e.x = x; e.y = y; e.l = 24'($urandom); e.r = 24'($urandom); e.cyc = exp_cyc;
    col_valid_in = 1'b1;
    hcount_in    = x;
    vcount_in    = y;
    left_col_in  = e.l;
    right_col_in = e.r;
    if (accept) iq.push_back(e);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((iq.size() != 0 || wq.size() != 0 || eng_left != 0) && n < budget) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check({tag, "_drain"}, 32'(iq.size() + wq.size()), 32'd0);
  endtask

  initial begin
    int p, w0, f0;
    rst_n_in = 1'b0; col_valid_in = 1'b0; hcount_in = '0; vcount_in = '0;
    left_col_in = '0; right_col_in = '0;
    man_busy = 1'b0; man_valid = 1'b0; man_x = '0; man_y = '0; man_line = '0;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_col_ready", 32'(col_ready_out), 32'd1);
    check("rst_sad_valid", 32'(sad_valid_out), 32'd0);
    check("rst_sad_hcount", 32'(sad_hcount_out), 32'd0);
    check("rst_depth_valid", 32'(depth_valid_out), 32'd0);
    check("rst_depth_addr", 32'(depth_addr_out), 32'd0);
    check("rst_frame_done", 32'(frame_done_out), 32'd0);
    check("rst_drop", 32'(drop_count_out), 32'd0);
    check("rst_timeout", 32'(timeout_count_out), 32'd0);
    rst_n_in = 1'b1;
    tick();

    // Single issue: x=50,y=10 -> issue at +2, write addr 3250 data 7.
    eng_mode = 1; line_val = 8'd7;
    p = cyc;
    drive_col(11'd50, 10'd10, p + 2, 1'b1);
    tick(); col_valid_in = 1'b0;
    wait_drain("single", 60);

    // Overflow: 8 back-to-back columns, 5 accepted, 3 dropped, ready low from +5.
    line_val = 8'd3;
    p = cyc;
    for (int i = 0; i < 8; i++) begin
      check("ovf_ready", 32'(col_ready_out), (i < 5) ? 32'd1 : 32'd0);
      check("ovf_drop_running", 32'(drop_count_out), (i > 5) ? 32'(i - 5) : 32'd0);
      drive_col(11'(100 + i), 10'd20, p + 2 + 13 * i, i < 5);
      tick();
    end
    col_valid_in = 1'b0;
    check("ovf_drop_total", 32'(drop_count_out), 32'd3);
    wait_drain("overflow", 200);

    // Edge mask around x = OFFSET+KERNEL_SIZE-1 = 12.
    line_val = 8'd9;
    for (int k = 0; k < 3; k++) begin
      p = cyc;
      drive_col((k == 0) ? 11'd5 : (k == 1) ? 11'd11 : 11'd12, 10'd3, p + 2, 1'b1);
      tick(); col_valid_in = 1'b0;
      wait_drain("edge", 60);
    end

    // Watchdog: engine never returns a result; abort after 24 cycles, next column follows.
    eng_mode = 2;
    p = cyc;
    drive_col(11'd200, 10'd30, p + 2, 1'b1);
    tick();
    drive_col(11'd201, 10'd30, p + 27, 1'b1);
    tick(); col_valid_in = 1'b0;
    while (cyc < p + 25) tick();
    check("wd_before", 32'(timeout_count_out), 32'd0);
    tick();
    check("wd_first", 32'(timeout_count_out), 32'd1);
    while (cyc < p + 50) tick();
    check("wd_second_before", 32'(timeout_count_out), 32'd1);
    tick();
    check("wd_second", 32'(timeout_count_out), 32'd2);
    wait_drain("watchdog", 40);

    // Stray result while idle produces no write.
    eng_mode = 0;
    man_valid = 1'b1; man_x = 10'd60; man_y = 9'd1; man_line = 8'd77;
    tick(); man_valid = 1'b0;
    check("stray_no_write", 32'(depth_valid_out), 32'd0);
    tick();

    // Frame end write plus out-of-range results that must not write.
    eng_mode = 1; line_val = 8'd42;
    w0 = n_writes; f0 = n_fd;
    p = cyc;
    drive_col(11'd319, 10'd239, p + 2, 1'b1);
    tick(); col_valid_in = 1'b0;
    wait_drain("frame", 60);
    drive_col(11'd320, 10'd0, -1, 1'b1);
    tick(); col_valid_in = 1'b0;
    wait_drain("oob_x", 60);
    drive_col(11'd5, 10'd240, -1, 1'b1);
    tick(); col_valid_in = 1'b0;
    wait_drain("oob_y", 60);
    check("frame_write_count", 32'(n_writes - w0), 32'd1);
    check("frame_done_count", 32'(n_fd - f0), 32'd1);

    // Async reset in WAIT_RESULT clears outputs before any clock edge.
    eng_mode = 0;
    p = cyc;
    drive_col(11'd70, 10'd2, p + 2, 1'b1);
    tick(); col_valid_in = 1'b0;
    tick();
    tick(); man_busy = 1'b1;
    tick(); man_busy = 1'b0;
    tick();
    #2 rst_n_in = 1'b0;
    #1;
    check("arst_sad_valid", 32'(sad_valid_out), 32'd0);
    check("arst_sad_hcount", 32'(sad_hcount_out), 32'd0);
    check("arst_sad_vcount", 32'(sad_vcount_out), 32'd0);
    check("arst_sad_left", 32'(sad_left_out), 32'd0);
    check("arst_depth_addr", 32'(depth_addr_out), 32'd0);
    check("arst_depth_data", 32'(depth_data_out), 32'd0);
    check("arst_drop", 32'(drop_count_out), 32'd0);
    check("arst_timeout", 32'(timeout_count_out), 32'd0);
    check("arst_col_ready", 32'(col_ready_out), 32'd1);
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    tick();
    man_valid = 1'b1; man_x = 10'd70; man_y = 9'd2; man_line = 8'd5;
    tick(); man_valid = 1'b0;
    check("post_reset_no_write", 32'(depth_valid_out), 32'd0);
    tick();

    // Recovery after reset.
    eng_mode = 1; line_val = 8'd4;
    p = cyc;
    drive_col(11'd30, 10'd5, p + 2, 1'b1);
    tick(); col_valid_in = 1'b0;
    wait_drain("recover", 60);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
